ghostbus_byte_host: RTL and testbench

//  Host (initiator) end of the ghostbus: turns a byte-stream command protocol (UART/USB FIFO side)

---
 rtl/ghostbus_byte_host.sv | 202 ++++++++++++++++++++
 tb/tb_ghostbus_byte_host.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_byte_host.sv
// Ghostbus host: converts a byte-stream command protocol into ghostbus write/read strobes.
// Optional macro GB_HOST_AUTOINC_EN enables multi-word frames with address auto-increment.
module ghostbus_byte_host #(
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2,
    parameter logic [7:0]  ACK    = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    input  logic [DW-1:0] gb_din,
    output logic          gb_we,
    output logic          gb_re,
    output logic          busy
);
    localparam int unsigned ABYTES = AW / 8;
    localparam int unsigned DBYTES = DW / 8;
    localparam int unsigned NB     = (ABYTES > DBYTES) ? ABYTES : DBYTES;
    localparam int unsigned CW     = $clog2(NB) + 1;
    localparam int unsigned LW     = 4;

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_DATA, S_WR, S_ACK, S_RD, S_WAIT, S_RESP
    } state_t;

    state_t        r_state;
    logic          r_is_rd;
    logic [CW-1:0] r_cnt;
    logic [LW-1:0] r_lat;
    logic [AW-1:0] r_asr;
    logic [DW-1:0] r_word;
    logic          r_rx_ready;
    logic          r_busy;
    logic          r_tx_valid;
    logic [7:0]    r_tx_data;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_dout;
    logic          r_we;
    logic          r_re;
`ifdef GB_HOST_AUTOINC_EN
    logic [6:0]    r_left;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CMD;
            r_is_rd    <= 1'b0;
            r_cnt      <= '0;
            r_lat      <= '0;
            r_asr      <= '0;
            r_word     <= '0;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
`ifdef GB_HOST_AUTOINC_EN
            r_left     <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;
            case (r_state)
                S_CMD: begin
                    if (rx_valid) begin
                        r_is_rd <= rx_data[7];
`ifdef GB_HOST_AUTOINC_EN
                        r_left  <= rx_data[6:0];
`endif
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADDR;
                    end
                end
                // Address assembled off-bus so gb_addr holds its old value until complete
                S_ADDR: begin
                    if (rx_valid) begin
                        r_asr <= AW'({r_asr, rx_data});
                        if (r_cnt == CW'(ABYTES - 1)) begin
                            r_addr <= AW'({r_asr, rx_data});
                            r_cnt  <= '0;
                            if (r_is_rd) begin
                                r_rx_ready <= 1'b0;
                                r_re       <= 1'b1;
                                r_state    <= S_RD;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_dout <= DW'({r_dout, rx_data});
                        if (r_cnt == CW'(DBYTES - 1)) begin
                            r_cnt      <= '0;
                            r_rx_ready <= 1'b0;
                            r_we       <= 1'b1;
                            r_state    <= S_WR;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_WR: begin
`ifdef GB_HOST_AUTOINC_EN
                    if (r_left != 7'd0) begin
                        r_left     <= r_left - 7'd1;
                        r_addr     <= r_addr + AW'(1);
                        r_rx_ready <= 1'b1;
                        r_state    <= S_DATA;
                    end else begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= ACK;
                        r_state    <= S_ACK;
                    end
`else
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= ACK;
                    r_state    <= S_ACK;
`endif
                end
                S_ACK: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_CMD;
                    end
                end
                S_RD: begin
                    r_lat   <= LW'(1);
                    r_state <= S_WAIT;
                end
                // Latency counter: r_lat equals cycles elapsed since the gb_re cycle
                S_WAIT: begin
                    if (r_lat == LW'(RD_LAT)) begin
                        r_tx_data  <= gb_din[DW-1 -: 8];
                        r_word     <= gb_din << 8;
                        r_tx_valid <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_RESP;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                S_RESP: begin
                    if (tx_ready) begin
                        if (r_cnt == CW'(DBYTES - 1)) begin
                            r_tx_valid <= 1'b0;
                            r_cnt      <= '0;
`ifdef GB_HOST_AUTOINC_EN
                            if (r_left != 7'd0) begin
                                r_left  <= r_left - 7'd1;
                                r_addr  <= r_addr + AW'(1);
                                r_re    <= 1'b1;
                                r_state <= S_RD;
                            end else begin
                                r_rx_ready <= 1'b1;
                                r_busy     <= 1'b0;
                                r_state    <= S_CMD;
                            end
`else
                            r_rx_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_CMD;
`endif
                        end else begin
                            r_tx_data <= r_word[DW-1 -: 8];
                            r_word    <= r_word << 8;
                            r_cnt     <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= S_CMD;
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign busy     = r_busy;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign gb_addr  = r_addr;
    assign gb_dout  = r_dout;
    assign gb_we    = r_we;
    assign gb_re    = r_re;

endmodule

// File: tb/tb_ghostbus_byte_host.sv
// Directed bench for ghostbus_byte_host with a fixed-latency responder model.
// Auto-increment scenarios are compiled when GB_HOST_AUTOINC_EN is defined.
module tb_ghostbus_byte_host;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned RD_LAT = 2;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic [DW-1:0] gb_din;
    logic          gb_we;
    logic          gb_re;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;
    int unsigned cyc = 0;
    int unsigned last_rx_cyc = 0;
    int unsigned we_cyc = 0;
    int unsigned re_cyc = 0;
    int both_viol = 0;
    int hold_viol = 0;
    bit tx_mode = 1'b0;
    logic p_valid = 1'b0, p_ready = 1'b0;
    logic [7:0] p_data = 8'h00;

    logic [AW-1:0] we_addr[$];
    logic [DW-1:0] we_data[$];
    logic [AW-1:0] re_addr[$];
    logic [7:0]    tx_q[$];
    byte_q_t fr, ex;

    ghostbus_byte_host #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .ACK(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_din(gb_din),
        .gb_we(gb_we), .gb_re(gb_re), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: read data appears exactly RD_LAT cycles after the gb_re cycle
    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return (a == 24'h000040) ? 32'h0000_007C : {8'h5A, a};
    endfunction

    logic [RD_LAT-1:0] re_sh = '0;
    logic [AW-1:0]     apipe[RD_LAT];
    always @(posedge clk) begin
        re_sh    <= {re_sh[RD_LAT-2:0], gb_re};
        apipe[0] <= gb_addr;
        for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign gb_din = re_sh[RD_LAT-1] ? rdata(apipe[RD_LAT-1]) : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        #1;
        if (tx_mode) tx_ready = ~tx_ready;
        else         tx_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (gb_we) begin we_addr.push_back(gb_addr); we_data.push_back(gb_dout); we_cyc = cyc; end
        if (gb_re) begin re_addr.push_back(gb_addr); re_cyc = cyc; end
        if (gb_we && gb_re) both_viol++;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (p_valid && !p_ready && (tx_valid !== 1'b1 || tx_data !== p_data)) hold_viol++;
        p_valid = tx_valid; p_ready = tx_ready; p_data = tx_data;
    end

    task automatic clear_logs();
        we_addr.delete(); we_data.delete(); re_addr.delete(); tx_q.delete();
        hold_viol = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data = b; rx_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = rx_ready;
            if (acc) last_rx_cyc = cyc;
            @(posedge clk); #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            n_vec++; n_bad++;
            $display("FAIL rx_accept: byte %h not accepted within 100 cycles", b);
        end
    endtask

    task automatic send_frame(input bit gaps);
        foreach (fr[i]) send_byte(fr[i], gaps ? (i % 6) : 0);
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        int n = 0;
        while (!idle && n < 400) begin
            @(negedge clk); idle = !busy && !tx_valid;
            @(posedge clk); #1; n++;
        end
        n_vec++;
        if (!idle) begin n_bad++; $display("FAIL %s_idle: busy=%b still after 400 cycles, want 0", name, busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (gb_we !== 1'b0)   begin n_bad++; $display("FAIL rst_we: got %b want 0", gb_we); end
        n_vec++; if (gb_re !== 1'b0)   begin n_bad++; $display("FAIL rst_re: got %b want 0", gb_re); end
        n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_txv: got %b want 0", tx_valid); end
        n_vec++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rxrdy: got %b want 1", rx_ready); end
        n_vec++; if (gb_addr !== 24'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 000000", gb_addr); end
        n_vec++; if (gb_dout !== 32'h0) begin n_bad++; $display("FAIL rst_dout: got %h want 00000000", gb_dout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        clear_logs();
        fr = '{8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(1'b0);
        wait_idle("wr");
        n_vec++; if (we_addr.size() !== 1) begin n_bad++; $display("FAIL wr_count: got %0d strobes want 1", we_addr.size()); end
        else begin
            n_vec++; if (we_addr[0] !== 24'h000010) begin n_bad++; $display("FAIL wr_addr: got %h want 000010", we_addr[0]); end
            n_vec++; if (we_data[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_data: got %h want deadbeef", we_data[0]); end
            n_vec++; if (we_cyc !== last_rx_cyc + 1) begin n_bad++; $display("FAIL wr_timing: we at %0d want %0d", we_cyc, last_rx_cyc + 1); end
        end
        n_vec++; if (re_addr.size() !== 0) begin n_bad++; $display("FAIL wr_no_re: got %0d read strobes want 0", re_addr.size()); end
        n_vec++; if (tx_q.size() !== 1 || tx_q[0] !== 8'hA5) begin n_bad++; $display("FAIL wr_ack: got %0d bytes first %h want 1 byte a5", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx); end
        n_vec++; if (gb_addr !== 24'h000010) begin n_bad++; $display("FAIL wr_addr_hold: got %h want 000010", gb_addr); end
    endtask

    task automatic test_read();
        clear_logs();
        fr = '{8'h80, 8'h00, 8'h00, 8'h40};
        ex = '{8'h00, 8'h00, 8'h00, 8'h7C};
        send_frame(1'b0);
        wait_idle("rd");
        n_vec++; if (re_addr.size() !== 1 || re_addr[0] !== 24'h000040) begin n_bad++; $display("FAIL rd_strobe: got %0d strobes want 1 at 000040", re_addr.size()); end
        n_vec++; if (re_cyc !== last_rx_cyc + 1) begin n_bad++; $display("FAIL rd_timing: re at %0d want %0d", re_cyc, last_rx_cyc + 1); end
        n_vec++; if (tx_q.size() !== ex.size()) begin n_bad++; $display("FAIL rd_len: got %0d bytes want %0d", tx_q.size(), ex.size()); end
        else foreach (ex[i]) begin
            n_vec++; if (tx_q[i] !== ex[i]) begin n_bad++; $display("FAIL rd_byte%0d: got %h want %h", i, tx_q[i], ex[i]); end
        end
    endtask

    task automatic test_read_backpressure();
        clear_logs();
        tx_mode = 1'b1;
        fr = '{8'h80, 8'h12, 8'h34, 8'h56};
        ex = '{8'h5A, 8'h12, 8'h34, 8'h56};
        send_frame(1'b0);
        wait_idle("bp");
        tx_mode = 1'b0;
        n_vec++; if (tx_q.size() !== ex.size()) begin n_bad++; $display("FAIL bp_len: got %0d bytes want %0d", tx_q.size(), ex.size()); end
        else foreach (ex[i]) begin
            n_vec++; if (tx_q[i] !== ex[i]) begin n_bad++; $display("FAIL bp_byte%0d: got %h want %h", i, tx_q[i], ex[i]); end
        end
        n_vec++; if (hold_viol !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d hold violations want 0", hold_viol); end
    endtask

    task automatic test_gaps();
        clear_logs();
        fr = '{8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        send_frame(1'b1);
        wait_idle("gapw");
        fr = '{8'h80, 8'hAB, 8'hCD, 8'hEF};
        send_frame(1'b1);
        wait_idle("gapr");
        ex = '{8'hA5, 8'h5A, 8'hAB, 8'hCD, 8'hEF};
        n_vec++; if (we_addr.size() !== 1 || we_addr[0] !== 24'hABCDEF || we_data[0] !== 32'h01234567) begin
            n_bad++; $display("FAIL gap_wr: got %0d strobes want 1 at abcdef data 01234567", we_addr.size()); end
        n_vec++; if (re_addr.size() !== 1 || re_addr[0] !== 24'hABCDEF) begin n_bad++; $display("FAIL gap_rd: got %0d strobes want 1 at abcdef", re_addr.size()); end
        n_vec++; if (tx_q.size() !== ex.size()) begin n_bad++; $display("FAIL gap_len: got %0d bytes want %0d", tx_q.size(), ex.size()); end
        else foreach (ex[i]) begin
            n_vec++; if (tx_q[i] !== ex[i]) begin n_bad++; $display("FAIL gap_byte%0d: got %h want %h", i, tx_q[i], ex[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        clear_logs();
        send_byte(8'h80, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || rx_ready !== 1'b1 || gb_addr !== 24'h0) begin
            n_bad++; $display("FAIL mid_rst_state: busy=%b rx_ready=%b addr=%h want 0 1 000000", busy, rx_ready, gb_addr); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        n_vec++; if (we_addr.size() + re_addr.size() !== 0) begin n_bad++; $display("FAIL mid_rst_strobe: got %0d strobes want 0", we_addr.size() + re_addr.size()); end
        fr = '{8'h80, 8'h00, 8'h00, 8'h40};
        ex = '{8'h00, 8'h00, 8'h00, 8'h7C};
        send_frame(1'b0);
        wait_idle("mid");
        n_vec++; if (re_addr.size() !== 1 || re_addr[0] !== 24'h000040) begin n_bad++; $display("FAIL mid_rd: got %0d strobes want 1 at 000040", re_addr.size()); end
        n_vec++; if (tx_q.size() !== ex.size()) begin n_bad++; $display("FAIL mid_len: got %0d bytes want %0d", tx_q.size(), ex.size()); end
        else foreach (ex[i]) begin
            n_vec++; if (tx_q[i] !== ex[i]) begin n_bad++; $display("FAIL mid_byte%0d: got %h want %h", i, tx_q[i], ex[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
`ifdef GB_HOST_AUTOINC_EN
        fr = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h80, 8'h00, 8'h00, 8'h02};
`else
        fr = '{8'h7F, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44,
               8'hFF, 8'h00, 8'h00, 8'h02};
`endif
        ex = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h02};
        send_frame(1'b0);
        wait_idle("b2b");
        n_vec++; if (we_addr.size() !== 1 || we_addr[0] !== 24'h000001 || we_data[0] !== 32'h11223344) begin
            n_bad++; $display("FAIL b2b_wr: got %0d strobes want 1 at 000001 data 11223344", we_addr.size()); end
        n_vec++; if (re_addr.size() !== 1 || re_addr[0] !== 24'h000002) begin n_bad++; $display("FAIL b2b_rd: got %0d strobes want 1 at 000002", re_addr.size()); end
        n_vec++; if (tx_q.size() !== ex.size()) begin n_bad++; $display("FAIL b2b_len: got %0d bytes want %0d", tx_q.size(), ex.size()); end
        else foreach (ex[i]) begin
            n_vec++; if (tx_q[i] !== ex[i]) begin n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, tx_q[i], ex[i]); end
        end
        n_vec++; if (both_viol !== 0) begin n_bad++; $display("FAIL we_re_overlap: got %0d overlap cycles want 0", both_viol); end
    endtask

`ifdef GB_HOST_AUTOINC_EN
    task automatic test_autoinc();
        logic [AW-1:0] ea[4];
        ea[0] = 24'hFFFFFE; ea[1] = 24'hFFFFFF; ea[2] = 24'h000000; ea[3] = 24'h000001;
        clear_logs();
        fr = '{8'h83, 8'hFF, 8'hFF, 8'hFE};
        ex = '{8'h5A, 8'hFF, 8'hFF, 8'hFE, 8'h5A, 8'hFF, 8'hFF, 8'hFF,
               8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h01};
        send_frame(1'b0);
        wait_idle("ai_rd");
        n_vec++; if (re_addr.size() !== 4) begin n_bad++; $display("FAIL ai_rd_count: got %0d want 4", re_addr.size()); end
        else foreach (ea[i]) begin
            n_vec++; if (re_addr[i] !== ea[i]) begin n_bad++; $display("FAIL ai_rd_addr%0d: got %h want %h", i, re_addr[i], ea[i]); end
        end
        n_vec++; if (tx_q.size() !== ex.size()) begin n_bad++; $display("FAIL ai_len: got %0d bytes want %0d", tx_q.size(), ex.size()); end
        else foreach (ex[i]) begin
            n_vec++; if (tx_q[i] !== ex[i]) begin n_bad++; $display("FAIL ai_byte%0d: got %h want %h", i, tx_q[i], ex[i]); end
        end
        clear_logs();
        fr = '{8'h01, 8'h00, 8'h00, 8'h20, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(1'b0);
        wait_idle("ai_wr");
        n_vec++; if (we_addr.size() !== 2 || we_addr[0] !== 24'h000020 || we_addr[1] !== 24'h000021 ||
                     we_data[0] !== 32'hAABBCCDD || we_data[1] !== 32'h11223344) begin
            n_bad++; $display("FAIL ai_wr: got %0d strobes want 2 at 000020/000021", we_addr.size()); end
        n_vec++; if (tx_q.size() !== 1 || tx_q[0] !== 8'hA5) begin n_bad++; $display("FAIL ai_ack: got %0d bytes want single a5", tx_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_backpressure();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
`ifdef GB_HOST_AUTOINC_EN
        test_autoinc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
